// File: rtl/axis_insert_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axis_insert_pkg
//  Description : Shared types and helpers for the AXI-Stream header inserter.
//                - state_e     : inserter FSM state encoding
//                - BYTE_WD     : bits per byte lane
//                - MAX_KEEP_WD : widest keep vector count_ones() accepts
//                - count_ones  : population count of a keep mask
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_insert_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   localparam int BYTE_WD     = 8;
   localparam int MAX_KEEP_WD = 64;

   // Number of set bits in a (zero-extended) keep mask.
   function automatic int unsigned count_ones(input logic [MAX_KEEP_WD-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_KEEP_WD; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : axis_byte_merge
//  Description : Combinational byte aligner. Concatenates the held word above
//                the incoming word and shifts the pair left by (W - shift_n)
//                bytes so the shift_n held bytes land at the top of the beat.
//  Ports       :
//    hold_data     in   DATA_WD        previously held word (header or data)
//    hold_keep     in   DATA_BYTE_WD   byte enables of the held word
//    data          in   DATA_WD        incoming word (zero when flushing)
//    keep          in   DATA_BYTE_WD   byte enables of the incoming word
//    shift_n       in   BYTE_CNT_WD+1  header byte count N, 0..W
//    merged_data   out  DATA_WD        upper W bytes of the shifted pair
//    merged_keep   out  DATA_BYTE_WD   upper W keep bits of the shifted pair
//    residual_keep out  DATA_BYTE_WD   lower W keep bits (bytes left over)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_byte_merge
   import axis_insert_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic [DATA_WD-1:0]      hold_data,
   input  logic [DATA_BYTE_WD-1:0] hold_keep,
   input  logic [DATA_WD-1:0]      data,
   input  logic [DATA_BYTE_WD-1:0] keep,
   input  logic [BYTE_CNT_WD:0]    shift_n,
   output logic [DATA_WD-1:0]      merged_data,
   output logic [DATA_BYTE_WD-1:0] merged_keep,
   output logic [DATA_BYTE_WD-1:0] residual_keep
);

   logic [BYTE_CNT_WD:0]        shift_bytes;
   logic [2*DATA_WD-1:0]        cat_data;
   logic [2*DATA_BYTE_WD-1:0]   cat_keep;
   logic                        unused_low;

   always_comb begin
      shift_bytes   = (BYTE_CNT_WD+1)'(DATA_BYTE_WD) - shift_n;
      cat_data      = {hold_data, data} << (32'(shift_bytes) * BYTE_WD);
      cat_keep      = {hold_keep, keep} << shift_bytes;
      merged_data   = cat_data[2*DATA_WD-1:DATA_WD];
      merged_keep   = cat_keep[2*DATA_BYTE_WD-1:DATA_BYTE_WD];
      residual_keep = cat_keep[DATA_BYTE_WD-1:0];
   end

   // The low data half is never emitted: residual bytes are re-derived from
   // the held word on the next beat.
   assign unused_low = ^cat_data[DATA_WD-1:0];

endmodule
`default_nettype wire

// File: rtl/axis_header_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_header_inserter
//  Description : AXI-Stream header inserter. Accepts one header word per
//                packet, keeps its N valid (LSB-aligned) bytes and prepends
//                them to the packet data, re-packing the merged byte stream
//                into full MSB-first beats. Registered output stage.
//  Build macro : AXIS_INSERT_KEEP_DERIVE_EN - when defined, N is the popcount
//                of keep_insert and byte_insert_cnt is ignored.
//  Ports       :
//    clk, rst_n         clock, asynchronous active-low reset
//    valid_in/ready_in  data beat handshake (data_in, keep_in, last_in)
//    valid_out/ready_out output beat handshake (data_out, keep_out, last_out)
//    valid_insert/ready_insert header handshake (header_insert,
//                       keep_insert, byte_insert_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_header_inserter
   import axis_insert_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      header_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
   output logic                    ready_insert
);

   state_e                  state_q, state_d;
   logic [DATA_WD-1:0]      hold_data_q, hold_data_d;
   logic [DATA_BYTE_WD-1:0] hold_keep_q, hold_keep_d;
   logic [BYTE_CNT_WD:0]    shift_n_q, shift_n_d;
   logic                    valid_out_q, valid_out_d;
   logic [DATA_WD-1:0]      data_out_q, data_out_d;
   logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
   logic                    last_out_q, last_out_d;
   logic                    ready_insert_q, ready_insert_d;

   logic                    slot_free;
   logic                    ready_in_w;
   logic [BYTE_CNT_WD:0]    n_sel;
   logic [DATA_WD-1:0]      merge_in_data;
   logic [DATA_BYTE_WD-1:0] merge_in_keep;
   logic [DATA_WD-1:0]      merged_data;
   logic [DATA_BYTE_WD-1:0] merged_keep;
   logic [DATA_BYTE_WD-1:0] residual_keep;

`ifdef AXIS_INSERT_KEEP_DERIVE_EN
   logic unused_cnt;
   assign n_sel      = (BYTE_CNT_WD+1)'(count_ones(MAX_KEEP_WD'(keep_insert)));
   assign unused_cnt = ^byte_insert_cnt;
`else
   assign n_sel = byte_insert_cnt;
`endif

   // The output register can take a new beat when empty or draining now.
   assign slot_free  = !valid_out_q || ready_out;
   assign ready_in_w = (state_q == STREAM) && slot_free;

   // In FLUSH only the held residue is emitted, so the low half is zero.
   assign merge_in_data = (state_q == FLUSH) ? '0 : data_in;
   assign merge_in_keep = (state_q == FLUSH) ? '0 : keep_in;

   axis_byte_merge #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD),
      .BYTE_CNT_WD  (BYTE_CNT_WD)
   ) u_merge (
      .hold_data     (hold_data_q),
      .hold_keep     (hold_keep_q),
      .data          (merge_in_data),
      .keep          (merge_in_keep),
      .shift_n       (shift_n_q),
      .merged_data   (merged_data),
      .merged_keep   (merged_keep),
      .residual_keep (residual_keep)
   );

   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      shift_n_d   = shift_n_q;
      valid_out_d = valid_out_q;
      data_out_d  = data_out_q;
      keep_out_d  = keep_out_q;
      last_out_d  = last_out_q;

      if (valid_out_q && ready_out) begin
         valid_out_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (valid_insert && ready_insert_q) begin
               hold_data_d = header_insert;
               hold_keep_d = keep_insert;
               shift_n_d   = n_sel;
               state_d     = STREAM;
            end
         end
         STREAM: begin
            if (valid_in && ready_in_w) begin
               data_out_d  = merged_data;
               keep_out_d  = merged_keep;
               valid_out_d = 1'b1;
               hold_data_d = data_in;
               hold_keep_d = keep_in;
               last_out_d  = 1'b0;
               if (last_in) begin
                  // Leftover bytes that did not fit need one extra beat.
                  if (residual_keep == '0) begin
                     last_out_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     state_d    = FLUSH;
                  end
               end
            end
         end
         FLUSH: begin
            if (slot_free) begin
               data_out_d  = merged_data;
               keep_out_d  = merged_keep;
               valid_out_d = 1'b1;
               last_out_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Header acceptance opens the cycle after the packet's final beat loads.
      ready_insert_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         hold_data_q    <= '0;
         hold_keep_q    <= '0;
         shift_n_q      <= '0;
         valid_out_q    <= 1'b0;
         data_out_q     <= '0;
         keep_out_q     <= '0;
         last_out_q     <= 1'b0;
         ready_insert_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_data_q    <= hold_data_d;
         hold_keep_q    <= hold_keep_d;
         shift_n_q      <= shift_n_d;
         valid_out_q    <= valid_out_d;
         data_out_q     <= data_out_d;
         keep_out_q     <= keep_out_d;
         last_out_q     <= last_out_d;
         ready_insert_q <= ready_insert_d;
      end
   end

   assign ready_in     = ready_in_w;
   assign valid_out    = valid_out_q;
   assign data_out     = data_out_q;
   assign keep_out     = keep_out_q;
   assign last_out     = last_out_q;
   assign ready_insert = ready_insert_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_header_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_header_inserter
//  Description : Self-checking bench for axis_header_inserter. A byte-queue
//                reference model builds the expected output beats of each
//                packet; directed and random packets are driven under
//                several downstream ready patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_header_inserter;

   localparam int DATA_WD = 32;
   localparam int W       = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        ready_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out = 1'b0;
   logic        valid_insert = 1'b0;
   logic [31:0] header_insert = '0;
   logic [3:0]  keep_insert = '0;
   logic [2:0]  byte_insert_cnt = '0;
   logic        ready_insert;

   int    n_cmp = 0;
   int    n_err = 0;
   int    stable_err = 0;
   int    ro_mode = 0;
   int    last_base = 0;
   beat_t got_q[$];
   beat_t in_beats[$];
   beat_t exp_beats[$];

   axis_header_inserter #(.DATA_WD(DATA_WD)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_insert    (valid_insert),
      .header_insert   (header_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert)
   );

   always #5 clk = ~clk;

   // Downstream ready: 0 = always ready, 1 = alternating, 2 = random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ro_mode)
            0:       ready_out = 1'b1;
            1:       ready_out = ~ready_out;
            default: ready_out = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Output monitor: records accepted beats and watches stall stability.
   logic  prev_stall = 1'b0;
   beat_t prev_beat = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!valid_out || {data_out, keep_out, last_out} != prev_beat))
            stable_err++;
         if (valid_out && ready_out)
            got_q.push_back({data_out, keep_out, last_out});
         prev_stall = valid_out && !ready_out;
         prev_beat  = {data_out, keep_out, last_out};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_cmp++;
      n_err++;
      $display("FAIL %s: observed no DUT handshake, expected one within the cycle budget", tag);
   endtask

   function automatic logic [31:0] kmask(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   // Reference: header bytes then kept data bytes as one byte stream,
   // re-cut into W-byte MSB-first beats; the final beat carries last.
   task automatic model(input logic [31:0] h, input int n);
      logic [7:0] bytes[$];
      beat_t b;
      for (int k = W - n; k < W; k++) bytes.push_back(h[8*(W-1-k) +: 8]);
      foreach (in_beats[i])
         for (int k = 0; k < W; k++)
            if (in_beats[i].keep[W-1-k]) bytes.push_back(in_beats[i].data[8*(W-1-k) +: 8]);
      exp_beats.delete();
      while (bytes.size() > 0) begin
         b = '0;
         for (int k = 0; k < W && bytes.size() > 0; k++) begin
            b.data[8*(W-1-k) +: 8] = bytes.pop_front();
            b.keep[W-1-k] = 1'b1;
         end
         b.last = (bytes.size() == 0);
         exp_beats.push_back(b);
      end
   endtask

   task automatic send_header(input logic [31:0] h, input int n);
      int t = 0;
      valid_insert    = 1'b1;
      header_insert   = h;
      keep_insert     = 4'((1 << n) - 1);
      byte_insert_cnt = 3'(n);
      @(negedge clk);
      while (!ready_insert && t < 200) begin @(negedge clk); t++; end
      if (!ready_insert) timeout("header_wait");
      @(posedge clk);
      #1;
      valid_insert = 1'b0;
   endtask

   task automatic send_beat(input beat_t b);
      int t = 0;
      valid_in = 1'b1;
      data_in  = b.data;
      keep_in  = b.keep;
      last_in  = b.last;
      @(negedge clk);
      while (!ready_in && t < 200) begin @(negedge clk); t++; end
      if (!ready_in) timeout("data_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic run_packet(input string tag, input logic [31:0] h, input int n);
      int base;
      int t = 0;
      @(posedge clk);
      #1;
      base = got_q.size();
      last_base = base;
      model(h, n);
      send_header(h, n);
      foreach (in_beats[i]) send_beat(in_beats[i]);
      valid_in = 1'b0;
      last_in  = 1'b0;
      while (got_q.size() < base + exp_beats.size() && t < 1000) begin @(negedge clk); t++; end
      if (got_q.size() < base + exp_beats.size()) timeout({tag, "_out_wait"});
      repeat (4) @(negedge clk);
      chk({tag, "_nbeats"}, 32'(got_q.size() - base), 32'(exp_beats.size()));
      for (int i = 0; i < exp_beats.size() && base + i < got_q.size(); i++) begin
         chk($sformatf("%s_b%0d_data", tag, i), got_q[base+i].data & kmask(exp_beats[i].keep), exp_beats[i].data);
         chk($sformatf("%s_b%0d_keep", tag, i), 32'(got_q[base+i].keep), 32'(exp_beats[i].keep));
         chk($sformatf("%s_b%0d_last", tag, i), 32'(got_q[base+i].last), 32'(exp_beats[i].last));
      end
   endtask

   task automatic load_plan_packet(input logic [3:0] last_keep);
      in_beats.delete();
      in_beats.push_back({32'h0A0B0C0D, 4'b1111, 1'b0});
      in_beats.push_back({32'h0E0F0001, 4'b1111, 1'b0});
      in_beats.push_back({32'h02030405, 4'b1111, 1'b0});
      in_beats.push_back({32'h06070809, 4'b1111, 1'b0});
      in_beats.push_back({32'h000A0000, last_keep, 1'b1});
   endtask

   task automatic load_random_packet();
      int nb;
      int kb;
      nb = $urandom_range(1, 5);
      in_beats.delete();
      for (int i = 0; i < nb - 1; i++) in_beats.push_back({32'($urandom), 4'b1111, 1'b0});
      kb = $urandom_range(1, W);
      in_beats.push_back({32'($urandom), 4'(((1 << kb) - 1) << (W - kb)), 1'b1});
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_keep_out", 32'(keep_out), 32'd0);
      chk("rst_last_out", 32'(last_out), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd0);
      chk("rst_ready_insert", 32'(ready_insert), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Worked example with a FLUSH beat
      ro_mode = 0;
      load_plan_packet(4'b1100);
      run_packet("t1", 32'h0F0E0D0C, 3);
      chk("t1_first", got_q[last_base].data, 32'h0E0D0C0A);
      chk("t1_flush", got_q[last_base+5].data & 32'hFF000000, 32'h0A000000);
      chk("t1_flush_keep", 32'(got_q[last_base+5].keep), 32'h8);

      // Last beat fits: no FLUSH
      load_plan_packet(4'b1000);
      run_packet("t2", 32'h0F0E0D0C, 3);
      chk("t2_last", got_q[last_base+4].data, 32'h07080900);

      // N = 0 passthrough, N = W full-word header
      load_plan_packet(4'b1100);
      run_packet("n0", 32'hDEADBEEF, 0);
      load_plan_packet(4'b1110);
      run_packet("n4", 32'h11223344, 4);
      chk("n4_first", got_q[last_base].data, 32'h11223344);

      // Alternating backpressure
      ro_mode = 1;
      load_plan_packet(4'b1100);
      run_packet("bp", 32'h0F0E0D0C, 3);
      ro_mode = 0;

      // Data offered before any header must wait
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      data_in  = 32'h0A0B0C0D;
      keep_in  = 4'b1111;
      last_in  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("nohdr_ready_in_%0d", i), 32'(ready_in), 32'd0);
         chk($sformatf("nohdr_valid_out_%0d", i), 32'(valid_out), 32'd0);
      end
      load_plan_packet(4'b1100);
      run_packet("late_hdr", 32'h0F0E0D0C, 3);

      // Random packets under random backpressure
      ro_mode = 2;
      for (int p = 0; p < 25; p++) begin
         load_random_packet();
         run_packet($sformatf("rnd%0d", p), 32'($urandom), $urandom_range(0, W));
      end
      ro_mode = 0;

      // Reset in the middle of a packet
      @(posedge clk);
      #1;
      load_plan_packet(4'b1100);
      send_header(32'h0F0E0D0C, 3);
      send_beat(in_beats[0]);
      send_beat(in_beats[1]);
      valid_in = 1'b1;
      data_in  = in_beats[2].data;
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
      chk("mid_rst_data_out", data_out, 32'd0);
      chk("mid_rst_keep_out", 32'(keep_out), 32'd0);
      chk("mid_rst_last_out", 32'(last_out), 32'd0);
      chk("mid_rst_ready_in", 32'(ready_in), 32'd0);
      chk("mid_rst_ready_insert", 32'(ready_insert), 32'd0);
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      load_plan_packet(4'b1100);
      run_packet("post_rst", 32'h0F0E0D0C, 3);

      chk("stall_stability", 32'(stable_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
